// File: rtl/uart_msg_engine.sv
// uart_msg_engine
//   Traffic controller placed between the byte-level uart_rx and uart_tx cores.
//   After reset it sends a fixed banner string. The banner is sent again every
//   PERIOD_CYC cycles, and also on request. Received bytes are buffered in a
//   small FIFO and echoed back between banners. Bytes that arrive while the
//   FIFO is full are counted and raise a sticky overflow flag.
//
// Parameters
//   MSG_LEN     banner length in bytes (1..255)
//   MSG         banner string; byte 0 is the most significant byte
//   PERIOD_CYC  cycles between automatic banners; 0 disables them
//   FIFO_DEPTH  echo FIFO depth in bytes (power of 2, >= 2)
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   rx_data_i/rx_valid_i        byte from uart_rx (single-cycle valid)
//   rx_ready_o                  FIFO has room for a byte
//   tx_data_o/tx_valid_o        byte to uart_tx
//   tx_ready_i                  uart_tx accepts the byte this edge
//   msg_start_i                 one-cycle banner request
//   busy_o                      banner in progress
//   overflow_o                  sticky: at least one byte dropped
//   drop_cnt_o                  dropped-byte count, saturating at 255
//
// Build option
//   UART_MSG_ECHO_CRLF_EN  when defined, an echoed 0x0D is followed by an
//                          internally generated 0x0A.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | just out of reset; leaves for MSG on the first edge
// MSG   | sending the banner, byte index idx_q
// WAIT  | echoing FIFO bytes; starts a banner when one is pending

module uart_msg_engine #(
  parameter int unsigned            MSG_LEN    = 20,
  parameter logic [MSG_LEN*8-1:0]   MSG        = "hello tang nano 9K\r\n",
  parameter int unsigned            PERIOD_CYC = 27000000,
  parameter int unsigned            FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_ready_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  input  logic       msg_start_i,
  output logic       busy_o,
  output logic       overflow_o,
  output logic [7:0] drop_cnt_o
);

  localparam int unsigned    AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]    DEPTH_C  = FIFO_DEPTH[AW:0];
  localparam logic [7:0]     LAST_IDX = MSG_LEN[7:0] - 8'd1;
  localparam bit             PER_EN   = (PERIOD_CYC != 0);
  localparam logic [31:0]    PER_LAST = PERIOD_CYC - 32'd1;

  typedef enum logic [1:0] {IDLE, MSG_S, WAIT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        busy_q, busy_d;
  logic        pending_q, pending_d;
  logic [31:0] per_cnt_q, per_cnt_d;
  logic        overflow_q;
  logic [7:0]  drop_cnt_q;

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  logic xfer, push, pop, enter, req, expire, fifo_empty, crlf_go;

`ifdef UART_MSG_ECHO_CRLF_EN
  logic crlf_q, crlf_d;
`endif

  function automatic logic [7:0] msg_byte(input logic [7:0] i);
    return MSG[(MSG_LEN - 1 - 32'(i)) * 8 +: 8];
  endfunction

  assign rx_ready_o = (count_q != DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign push       = rx_valid_i && rx_ready_o;
  assign xfer       = tx_valid_q && tx_ready_i;

`ifdef UART_MSG_ECHO_CRLF_EN
  assign crlf_go = xfer && crlf_q;
`else
  assign crlf_go = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    pending_d  = pending_q;
    per_cnt_d  = per_cnt_q;
    pop        = 1'b0;
    enter      = 1'b0;
    req        = 1'b0;
    expire     = 1'b0;
`ifdef UART_MSG_ECHO_CRLF_EN
    crlf_d     = crlf_q;
`endif
    case (state_q)
      IDLE: enter = 1'b1;
      MSG_S: begin
        pending_d = pending_q || msg_start_i;
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
            state_d    = WAIT;
          end else begin
            idx_d     = idx_q + 8'd1;
            tx_data_d = msg_byte(idx_q + 8'd1);
          end
        end
      end
      WAIT: begin
        if (PER_EN) begin
          if (per_cnt_q == PER_LAST) expire = 1'b1;
          else                       per_cnt_d = per_cnt_q + 32'd1;
        end
        // expiry and msg_start can start a banner on the same edge; the flag
        // only remembers a request that has to wait for an echo in flight
        req       = pending_q || msg_start_i || expire;
        pending_d = req;
        if (crlf_go) begin
          // tx_valid stays high: the generated LF follows the CR back-to-back
          tx_data_d = 8'h0A;
`ifdef UART_MSG_ECHO_CRLF_EN
          crlf_d    = 1'b0;
`endif
        end else if (!tx_valid_q && req) begin
          enter = 1'b1;
        end else if ((!tx_valid_q || xfer) && !req && !fifo_empty) begin
          pop        = 1'b1;
          tx_valid_d = 1'b1;
          tx_data_d  = mem_q[rd_ptr_q];
`ifdef UART_MSG_ECHO_CRLF_EN
          crlf_d     = (mem_q[rd_ptr_q] == 8'h0D);
`endif
        end else if (xfer) begin
          tx_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter) begin
      state_d    = MSG_S;
      idx_d      = 8'd0;
      tx_data_d  = msg_byte(8'd0);
      tx_valid_d = 1'b1;
      busy_d     = 1'b1;
      pending_d  = 1'b0;
      per_cnt_d  = 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= 8'd0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      pending_q  <= 1'b0;
      per_cnt_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      pending_q  <= pending_d;
      per_cnt_q  <= per_cnt_d;
    end
  end

`ifdef UART_MSG_ECHO_CRLF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crlf_q <= 1'b0;
    else        crlf_q <= crlf_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else if (rx_valid_i && !rx_ready_o) begin
      overflow_q <= 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign busy_o     = busy_q;
  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: doc/uart_msg_engine.md
Name: uart_msg_engine

Overview:
Parametrised UART traffic controller that sits between the byte-level uart_rx and uart_tx cores.
- Sends a parametrised banner string once after reset, then once per programmable period or on demand.
- Echoes received bytes back through a FIFO, so bytes arriving during a banner are buffered rather than lost.
- Reports FIFO overflow and a count of dropped bytes.

Parameters:
MSG_LEN, 20, banner length in bytes (1..255).
MSG, "hello tang nano 9K\r\n", MSG_LEN*8-bit string; byte i = MSG[(MSG_LEN-1-i)*8 +: 8], so byte 0 is the MSB byte.
PERIOD_CYC, 27000000, clock cycles between automatic banners; 0 disables periodic banners.
FIFO_DEPTH, 16, echo FIFO depth in bytes; power of 2, minimum 2.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
rx_data  in  8  received byte from uart_rx
rx_valid  in  1  rx_data valid, single-cycle pulse
rx_ready  out  1  FIFO can accept a byte
tx_data  out  8  byte to uart_tx
tx_valid  out  1  tx_data valid
tx_ready  in  1  uart_tx accepts the byte
msg_start  in  1  one-cycle request to send the banner
busy  out  1  high while in state MSG
overflow  out  1  sticky: a byte was dropped; cleared only by reset
drop_cnt  out  8  dropped-byte count, saturates at 255

Behaviour:
- Clock and reset: clk; rst_n asynchronous, active-low.
- Reset values: tx_data=0, tx_valid=0, busy=0, overflow=0, drop_cnt=0, FIFO empty (rx_ready=1), state IDLE, period counter 0, pending=0.
- Reset mid-operation: the current byte is abandoned, FIFO contents are discarded, and the banner restarts from byte 0 after release.
- States:
  - IDLE: first posedge after reset release goes to MSG.
  - MSG: sends the banner.
  - WAIT: echoes FIFO bytes and waits for the next banner.
- Tx handshake:
  - A byte transfers on a posedge with tx_valid&&tx_ready.
  - While tx_valid=1 and tx_ready=0, tx_data and tx_valid stay stable.
  - tx_valid never drops without a transfer.
- MSG entry: the same edge sets tx_valid=1, tx_data=byte 0, busy=1, byte index=0.
- MSG, transfer of byte i < last: the same edge presents byte i+1 with tx_valid held high (no bubble).
- MSG, transfer of the last byte: tx_valid=0, busy=0, go to WAIT.
- WAIT, no tx byte pending and FIFO non-empty: pop the head, present it with tx_valid=1 on the next edge. Echo latency from an rx_valid into an empty FIFO is 2 cycles to tx_valid.
- WAIT, transfer of an echo byte: the same edge may present the next FIFO byte if one is available, else tx_valid=0.
- Pending flag:
  - Set by msg_start=1 or by period expiry.
  - WAIT goes to MSG only when pending=1 and tx_valid=0, so an echo byte in flight completes first.
  - msg_start during MSG sets pending, giving exactly one more banner afterwards.
- Period counter (32-bit):
  - Cleared on MSG entry; increments each cycle in WAIT.
  - At PERIOD_CYC-1 it sets pending and holds.
  - Inactive when PERIOD_CYC=0.
- FIFO:
  - Circular buffer with log2(FIFO_DEPTH)-bit pointers that wrap naturally and a (log2+1)-bit count.
  - rx_ready = (count != FIFO_DEPTH), combinational from registered count.
  - Push on rx_valid && rx_ready, in any state including MSG.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Full (count == FIFO_DEPTH): no push, even if a pop happens in the same cycle.
  - Drop: rx_valid && !rx_ready sets overflow and increments drop_cnt (saturating at 255); the byte is discarded.
  - Echo order is strict FIFO.

Optional Feature:
UART_MSG_ECHO_CRLF_EN
- Defined: when an echoed byte equals 0x0D, the engine transmits 0x0D then an extra 0x0A. The 0x0A is generated internally, not taken from the FIFO, and goes back-to-back before the next pop. A pending banner waits until the 0x0A completes.
- Not defined: bytes are echoed verbatim and no extra logic is present.

Test Plan:
- Reset release, tx_ready=1, MSG_LEN=4, MSG="AB\r\n": tx_valid rises 1 edge after release; bytes 0x41,0x42,0x0D,0x0A on 4 consecutive edges; then busy=0, tx_valid=0.
- tx_ready held low 10 cycles mid-banner: tx_data frozen at the current byte and tx_valid stays 1; the sequence resumes with no skipped or repeated byte.
- In WAIT, rx_valid with 0x55 then 0xAA, tx_ready=1: 0x55 then 0xAA appear on tx in order, first at 2 cycles after the first rx_valid.
- FIFO_DEPTH=4, tx_ready=0, 6 rx bytes: rx_ready=0 after the 4th; overflow=1; drop_cnt=2; after tx_ready=1 exactly the first 4 bytes are echoed.
- PERIOD_CYC=100: a banner restarts 100 cycles after the previous banner's end. msg_start during a banner gives exactly one extra banner. An echo byte in flight at expiry completes before the banner.
- With UART_MSG_ECHO_CRLF_EN, rx byte 0x0D: tx emits 0x0D then 0x0A. Without the macro, only 0x0D is emitted.
